// File: rtl/sc_pkg.sv
// Shared types and default constants for the stochastic-computing evaluation
// controller and its helper blocks.
package sc_pkg;

  localparam int              SC_WIDTH        = 8;
  localparam int              SC_STREAM_LEN   = 256;
  localparam logic [7:0]      SC_DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sc_eval_state_t;

endpackage

// File: rtl/sc_ones_counter.sv
// Counts the 1s on a stochastic bitstream; reusable by any SC decoder that
// needs a clearable, gated population count.
module sc_ones_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             sc_bit,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && sc_bit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sc_eval_controller.sv
// Sequences one SC evaluation: seed load, STREAM_LEN datapath steps, 1s count.
// Optional build macro SC_EVAL_PERF_CNT_EN adds the eval_count output.
module sc_eval_controller
  import sc_pkg::*;
#(
  parameter int               WIDTH        = SC_WIDTH,
  parameter int               STREAM_LEN   = SC_STREAM_LEN,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(SC_DEFAULT_SEED),
  localparam int              CNT_W        = $clog2(STREAM_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic [WIDTH-1:0] dp_state,
  output logic [WIDTH-1:0] dp_operand,
  input  logic [WIDTH-1:0] dp_next_state,
  input  logic             dp_bit,
  output logic [CNT_W-1:0] result,
  output logic             result_valid
`ifdef SC_EVAL_PERF_CNT_EN
  ,
  output logic [15:0]      eval_count
`endif
);

  sc_eval_state_t   state, state_nxt;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic             capture, load_seed, step, finish, last_cycle;

  assign last_cycle = (cyc_cnt == CNT_W'(STREAM_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_seed = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SEED;
        end
      end
      SEED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          load_seed = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last_cycle) state_nxt = DONE;
        end
      end
      DONE: begin
        // start and abort are both ignored here; the run always completes
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: only control/state registers are reset here; there is no memory
  // array, so every flop gets a defined value on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state     <= DEFAULT_SEED;
      dp_operand   <= '0;
      seed_q       <= DEFAULT_SEED;
      cyc_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= finish;
      if (capture) begin
        dp_operand <= operand;
        seed_q     <= (seed == '0) ? DEFAULT_SEED : seed;
      end
      if (load_seed) begin
        dp_state <= seed_q;
        cyc_cnt  <= '0;
      end
      if (step) begin
        dp_state <= dp_next_state;
        cyc_cnt  <= cyc_cnt + CNT_W'(1);
      end
      // ones_cnt already includes the final RUN sample when DONE is reached
      if (finish) result <= ones_cnt;
    end
  end

  sc_ones_counter #(
    .CNT_W (CNT_W)
  ) u_ones (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_seed),
    .enable (step),
    .sc_bit (dp_bit),
    .count  (ones_cnt)
  );

`ifdef SC_EVAL_PERF_CNT_EN
  // Counts completed evaluations only; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         eval_count <= '0;
    else if (finish) eval_count <= eval_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sc_eval_controller.sv
// Directed bench for sc_eval_controller with a stub datapath; build with
// SC_EVAL_PERF_CNT_EN defined to also exercise eval_count.
module tb_sc_eval_controller;
  import sc_pkg::*;

  localparam int L     = 256;
  localparam int CNT_W = $clog2(L + 1);
  localparam int LAT   = L + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [7:0]       seed, operand;
  logic             busy;
  logic [7:0]       dp_state, dp_operand, dp_next_state;
  logic             dp_bit;
  logic [CNT_W-1:0] result;
  logic             result_valid;
`ifdef SC_EVAL_PERF_CNT_EN
  logic [15:0]      eval_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;  // 0: bit=1, 1: bit=0, 2: bit=dp_state[0]
  int exp_evals = 0;

  always #5 clk = ~clk;

  always_comb begin
    dp_next_state = dp_state + 8'd1;
    case (mode)
      0:       dp_bit = 1'b1;
      1:       dp_bit = 1'b0;
      default: dp_bit = dp_state[0];
    endcase
  end

  sc_eval_controller dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .operand       (operand),
    .busy          (busy),
    .dp_state      (dp_state),
    .dp_operand    (dp_operand),
    .dp_next_state (dp_next_state),
    .dp_bit        (dp_bit),
    .result        (result),
    .result_valid  (result_valid)
`ifdef SC_EVAL_PERF_CNT_EN
    ,
    .eval_count    (eval_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full evaluation. hold_start keeps start high while busy;
  // abort_done raises abort during the DONE cycle.
  task automatic run_eval(input string tag, input logic [7:0] s, input logic [7:0] op,
                          input int md, input int exp_res, input logic [7:0] exp_first,
                          input bit hold_start, input bit abort_done, input bit abort_at_start);
    int cnt;
    bit seen;
    mode = md; seed = s; operand = op; start = 1'b1; abort = abort_at_start;
    tick();
    start = hold_start; abort = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    cnt = 0; seen = 0;
    while (!seen && cnt < 400) begin
      tick();
      cnt++;
      abort = abort_done && (cnt == L + 1);
      if (cnt == 1) check({tag, "_first_state"}, 32'(dp_state), 32'(exp_first));
      if (result_valid) seen = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
    check({tag, "_latency"}, 32'(cnt), 32'(LAT));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_operand"}, 32'(dp_operand), 32'(op));
    exp_evals++;
`ifdef SC_EVAL_PERF_CNT_EN
    check({tag, "_eval_count"}, 32'(eval_count), 32'(exp_evals));
`endif
    tick();
    check({tag, "_pulse_once"}, 32'(result_valid), 32'd0);
    check({tag, "_no_requeue"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; operand = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dp_state), 32'h01);
    check("rst_operand", 32'(dp_operand), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
`ifdef SC_EVAL_PERF_CNT_EN
    check("rst_eval_count", 32'(eval_count), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // start held high while busy: exactly one evaluation
    run_eval("hold_start", 8'h5A, 8'h40, 0, 256, 8'h5A, 1'b1, 1'b0, 1'b0);
    // all-zero stream, with abort in the DONE cycle being ignored
    run_eval("zeros", 8'h21, 8'h11, 1, 0, 8'h21, 1'b0, 1'b1, 1'b0);
    // zero seed -> default seed; start with abort in IDLE still starts
    run_eval("seed0", 8'h00, 8'hC3, 2, 128, 8'h01, 1'b0, 1'b0, 1'b1);
    run_eval("ones", 8'h5A, 8'h40, 0, 256, 8'h5A, 1'b0, 1'b0, 1'b0);

    // abort in RUN cycle 100
    mode = 0; seed = 8'h5A; operand = 8'h40; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (100) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_result_kept", 32'(result), 32'd256);
    pulses = 0;
    repeat (300) begin
      if (result_valid) pulses++;
      tick();
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    run_eval("post_abort", 8'h5A, 8'h40, 2, 128, 8'h5A, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-RUN, off the clock edge
    mode = 0; seed = 8'h33; operand = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(dp_state), 32'h01);
    check("arst_operand", 32'(dp_operand), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_valid", 32'(result_valid), 32'd0);
    exp_evals = 0;
`ifdef SC_EVAL_PERF_CNT_EN
    check("arst_eval_count", 32'(eval_count), 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("arst_idle", 32'(busy), 32'd0);
    run_eval("post_rst", 8'h33, 8'h77, 0, 256, 8'h33, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
